// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first, registered carry.
// Result, carry-out and overflow are latched in DONE and held until the next completed operation.

module FA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, msb_cin_q, msb_cin_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             fa_s, fa_co;

    FA u_fa (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    sa_d    = a;
                    sb_d    = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                sr_d    = {fa_s, sr_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Carry into the MSB is kept for the signed overflow test.
                    msb_cin_d = carry_q;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                result_d = sr_q;
                cout_d   = carry_q;
                ovf_d    = msb_cin_q ^ carry_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule
